fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 80 ++++++++
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   XLEN      : architectural word width
//   NOP_INST  : canonical nop (addi x0, x0, 0), used as the reset head
//               instruction and as the payload of misaligned-fetch entries
//   fetch_entry_t : one fetch buffer entry {pc, inst, misaligned}
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            misaligned;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  localparam fetch_entry_t ENTRY_RST = '{pc: '0, inst: NOP_INST, misaligned: 1'b0};

endpackage

// File: rtl/fetch_fifo.sv
// Small shifting FIFO used both as the fetch buffer and as the in-flight
// request address queue.  Entry 0 is always the head, so the head output is
// a plain register.  When the FIFO drains (or is cleared) the head register
// keeps its last contents instead of exposing stale storage.
//   clk, rst   : clock, asynchronous active-high reset (data -> RST_VAL)
//   clr        : synchronous clear of the occupancy; data is held
//   push       : write push_data behind the current tail
//   pop        : drop the head (ignored when empty)
//   head       : current head entry
//   count      : occupancy, 0..DEPTH
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] mem_nxt [DEPTH];
  logic             pop_eff;
  logic [CW-1:0]    wr_idx;

  assign head = mem[0];

  always_comb begin
    pop_eff = pop && (count != '0);
    // After a pop the tail slot moves down by one.
    wr_idx  = pop_eff ? count - CW'(1) : count;
    mem_nxt = mem;
    // Shift only while something remains behind the head; popping the last
    // entry leaves the head register untouched.
    if (pop_eff && (count > CW'(1))) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_nxt[i] = mem[i + 1];
      end
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wr_idx) begin
          mem_nxt[i] = push_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RST_VAL;
      end
    end else if (clr) begin
      count <= '0;
    end else begin
      mem   <= mem_nxt;
      count <= count + CW'(push) - CW'(pop_eff);
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && !clr) begin
      assert (!(push && !pop_eff && (count == CW'(DEPTH))))
        else $error("fetch_fifo: push into full fifo");
      assert (!(pop && (count == '0)))
        else $error("fetch_fifo: pop from empty fifo");
    end
  end
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches at the current pc under a
// credit scheme, buffers returned instructions for decode, and handles
// redirects (flush) by dropping responses that were already in flight.
//   DEPTH          : buffer entries / max in-flight requests (2..4)
//   clk, rst       : clock, asynchronous active-high reset
//   pc, pc_en      : PC register value and its write enable
//   flush          : redirect from execute (PC mux selects the target)
//   imem_req_*     : request valid/addr/ready
//   imem_rsp_*     : in-order response valid/data
//   if_*           : head of the fetch buffer toward decode
//   id_ready       : decode accepts the head
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic            pc_en,
  input  logic            flush,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst,
  input  logic            id_ready,
  output logic            if_misaligned
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 2;

  logic [CW-1:0]   buf_count;
  logic [CW-1:0]   aq_count;
  logic [CW-1:0]   discard;
  logic            halt;
  fetch_entry_t    head;
  fetch_entry_t    buf_wdata;
  logic [XLEN-1:0] aq_head;
  logic [SW-1:0]   in_use;
  logic            credit;
  logic            pc_misaligned;
  logic            issue_ok;
  logic            accepted;
  logic            mis_wr;
  logic            rsp_live;
  logic            rsp_any;
  logic            buf_push;
  logic            buf_pop;

  // Every buffer slot is either occupied, owed to a live request, or owed to
  // a request whose response will be dropped.
  assign in_use        = SW'(buf_count) + SW'(aq_count) + SW'(discard);
  assign credit        = in_use < SW'(DEPTH);
  assign pc_misaligned = pc[1:0] != 2'b00;
  assign issue_ok      = !flush && !rst && !halt && credit;

  assign imem_req_valid = issue_ok && !pc_misaligned;
  assign imem_req_addr  = pc;
  assign accepted       = imem_req_valid && imem_req_ready;
  assign pc_en          = !rst && (accepted || flush);

  // The misaligned entry waits until all older live fetches have landed so
  // the buffer stays in program order; this also keeps it from colliding
  // with a response write.
  assign mis_wr   = issue_ok && pc_misaligned && (aq_count == '0);
  assign rsp_live = imem_rsp_valid && (discard == '0) && (aq_count != '0);
  assign rsp_any  = imem_rsp_valid && ((discard != '0) || (aq_count != '0));
  assign buf_push = !flush && (rsp_live || mis_wr);

  always_comb begin
    if (mis_wr) begin
      buf_wdata = '{pc: pc, inst: NOP_INST, misaligned: 1'b1};
    end else begin
      buf_wdata = '{pc: aq_head, inst: imem_rsp_data, misaligned: 1'b0};
    end
  end

  assign if_valid      = buf_count != '0;
  assign buf_pop       = if_valid && id_ready;
  assign if_pc         = head.pc;
  assign if_inst       = head.inst;
  assign if_misaligned = head.misaligned;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .WIDTH   (ENTRY_W),
    .RST_VAL (ENTRY_RST)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .push      (buf_push),
    .push_data (buf_wdata),
    .pop       (buf_pop),
    .head      (head),
    .count     (buf_count)
  );

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .WIDTH   (XLEN),
    .RST_VAL ('0)
  ) u_addrq (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .push      (accepted),
    .push_data (pc),
    .pop       (rsp_live),
    .head      (aq_head),
    .count     (aq_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard <= '0;
      halt    <= 1'b0;
    end else if (flush) begin
      // Everything still owed becomes discard, except a response that is
      // landing right now (it is dropped this cycle).
      discard <= discard + aq_count - CW'(rsp_any);
      halt    <= 1'b0;
    end else begin
      if (imem_rsp_valid && (discard != '0)) begin
        discard <= discard - CW'(1);
      end
      if (mis_wr) begin
        halt <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rsp_valid && !rsp_any))
        else $error("fetch_unit: response with no request in flight");
      assert (in_use <= SW'(DEPTH))
        else $error("fetch_unit: credit counters overflow");
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_en;
  logic        flush;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;
  logic        if_misaligned;

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .pc_en          (pc_en),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .id_ready       (id_ready),
    .if_misaligned  (if_misaligned)
  );

  always #5 clk = ~clk;

  // Outstanding memory request; stale ones were overtaken by a redirect.
  typedef struct { logic [31:0] addr; bit stale; int cyc; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic mis; } ent_t;

  mreq_t memq[$];
  ent_t  fbuf[$];
  ent_t  last_head;
  bit    halted;
  int    cyc;
  int    errors = 0;
  int    checks = 0;

  int          p_ready, p_idr, p_rsp, p_flush;
  bit          force_flush;
  logic [31:0] flush_tgt;
  logic [31:0] pc_next;

  logic        o_req, o_pc_en, o_ifv, o_mis;
  logic [31:0] o_addr, o_ifpc, o_inst;

  function automatic logic [31:0] inst_of(logic [31:0] a);
    return (a ^ 32'h1357_9BDF) + 32'h0000_0777;
  endfunction

  function automatic bit roll(int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    bit          exp_req, exp_ifv, acc, mis, got_rsp;
    int          live;
    ent_t        h, e;
    mreq_t       r;
    logic [31:0] tgt;
    @(negedge clk);
    pc = pc_next;
    flush = force_flush || roll(p_flush);
    if (force_flush) tgt = flush_tgt;
    else begin
      tgt = $urandom & 32'h0000_FFFC;
      if (roll(15)) tgt = tgt | 32'h2;
    end
    imem_req_ready = roll(p_ready);
    id_ready       = roll(p_idr);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (memq.size() != 0 && memq[0].cyc < cyc && roll(p_rsp)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(memq[0].addr);
    end
    #1;
    o_req = imem_req_valid; o_addr = imem_req_addr; o_pc_en = pc_en;
    o_ifv = if_valid; o_ifpc = if_pc; o_inst = if_inst; o_mis = if_misaligned;

    live = 0;
    foreach (memq[i]) if (!memq[i].stale) live++;
    exp_ifv = fbuf.size() != 0;
    h       = exp_ifv ? fbuf[0] : last_head;
    exp_req = !flush && !halted && pc[1:0] == 2'b00 && (memq.size() + fbuf.size() < DEPTH);
    mis     = !flush && !halted && pc[1:0] != 2'b00 && (memq.size() + fbuf.size() < DEPTH) && live == 0;
    acc     = exp_req && imem_req_ready;

    chk("req_valid", 32'(o_req), 32'(exp_req));
    chk("req_addr", o_addr, pc);
    chk("pc_en", 32'(o_pc_en), 32'(acc || flush));
    chk("if_valid", 32'(o_ifv), 32'(exp_ifv));
    chk("if_pc", o_ifpc, h.pc);
    chk("if_inst", o_inst, h.inst);
    chk("if_misaligned", 32'(o_mis), 32'(h.mis));
    last_head = h;

    got_rsp = imem_rsp_valid;
    r = '{addr: 32'h0, stale: 1'b1, cyc: 0};
    if (got_rsp) r = memq.pop_front();
    if (flush) begin
      fbuf.delete();
      foreach (memq[i]) memq[i].stale = 1'b1;
      halted = 1'b0;
    end else begin
      if (exp_ifv && id_ready) void'(fbuf.pop_front());
      if (got_rsp && !r.stale) begin
        e = '{pc: r.addr, inst: imem_rsp_data, mis: 1'b0};
        fbuf.push_back(e);
      end
      if (mis) begin
        e = '{pc: pc, inst: NOP_INST, mis: 1'b1};
        fbuf.push_back(e);
        halted = 1'b1;
      end
      if (acc) memq.push_back('{addr: pc, stale: 1'b0, cyc: cyc});
    end
    // The PC register follows the DUT's own enable.
    pc_next = o_pc_en ? (flush ? tgt : pc + 32'd4) : pc;
    cyc++;
  endtask

  task automatic do_reset(bit mid);
    if (mid) begin
      @(posedge clk);
      #2;
    end
    rst = 1'b1;
    flush = 1'b0; id_ready = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    #1;
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_inst", if_inst, NOP_INST);
    chk("rst_if_mis", 32'(if_misaligned), 32'd0);
    memq.delete();
    fbuf.delete();
    halted = 1'b0;
    last_head = '{pc: 32'h0, inst: NOP_INST, mis: 1'b0};
    pc = 32'h0;
    pc_next = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic knobs(int r, int i, int s, int f);
    p_ready = r; p_idr = i; p_rsp = s; p_flush = f;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    bit          found;
    logic [31:0] pc0;
    logic [31:0] ifpc_rec [6];
    logic        ifv_rec  [6];
    logic        req_rec  [6];
    rst = 1'b0; pc = 32'h0; flush = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; id_ready = 1'b0;
    force_flush = 1'b0; flush_tgt = 32'h0; cyc = 0;
    knobs(100, 100, 100, 0);
    #1;
    do_reset(0);

    // Streaming after reset release.
    for (int k = 0; k < 6; k++) begin
      step();
      ifpc_rec[k] = o_ifpc; ifv_rec[k] = o_ifv; req_rec[k] = o_req;
    end
    n = 0;
    for (int k = 0; k < 3; k++) if (req_rec[k]) n++;
    chk("b2b_requests", 32'(n), 32'd3);
    chk("stream_pc0", ifpc_rec[2], 32'h0);
    chk("stream_pc4", ifpc_rec[3], 32'h4);
    chk("stream_pc8", ifpc_rec[4], 32'h8);
    n = 0;
    for (int k = 2; k < 6; k++) if (ifv_rec[k]) n++;
    chk("stream_continuous", 32'(n), 32'd4);

    // Decode stall fills the buffer.
    do_reset(0);
    knobs(100, 0, 100, 0);
    repeat (6) step();
    chk("full_req_drop", 32'(o_req), 32'd0);
    chk("full_head_pc", o_ifpc, 32'h0);
    knobs(0, 100, 100, 0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (!o_ifv) break;
      n++;
    end
    chk("buffered_entries", 32'(n), 32'(DEPTH));

    // Flush with two requests in flight.
    do_reset(0);
    knobs(100, 100, 0, 0);
    n = 0;
    repeat (2) begin
      step();
      if (o_pc_en) n++;
    end
    chk("two_in_flight", 32'(n), 32'd2);
    force_flush = 1'b1; flush_tgt = 32'h100;
    step();
    force_flush = 1'b0;
    knobs(100, 100, 100, 0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (o_ifv) begin
        found = 1'b1;
        chk("flush_first_pc", o_ifpc, 32'h100);
      end
    end
    if (!found) chk("flush_timeout", 32'd0, 32'd1);

    // Memory not ready.
    knobs(0, 100, 100, 0);
    pc0 = pc_next;
    n = 0;
    repeat (3) begin
      step();
      if (o_pc_en) n++;
    end
    chk("ready_low_pc_en", 32'(n), 32'd0);
    chk("ready_low_pc_held", pc_next, pc0);
    knobs(100, 100, 100, 0);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      step();
      if (o_pc_en) found = 1'b1;
    end
    chk("ready_resume", 32'(found), 32'd1);

    // Misaligned redirect, then recovery.
    knobs(100, 0, 100, 0);
    force_flush = 1'b1; flush_tgt = 32'h102;
    step();
    force_flush = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (o_ifv) begin
        found = 1'b1;
        chk("mis_flag", 32'(o_mis), 32'd1);
        chk("mis_inst", o_inst, NOP_INST);
        chk("mis_pc", o_ifpc, 32'h102);
      end
    end
    if (!found) chk("mis_timeout", 32'd0, 32'd1);
    knobs(100, 100, 100, 0);
    n = 0;
    repeat (4) begin
      step();
      if (o_req) n++;
    end
    chk("mis_no_request", 32'(n), 32'd0);
    force_flush = 1'b1; flush_tgt = 32'h200;
    step();
    force_flush = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (o_req) begin
        found = 1'b1;
        chk("mis_resume_addr", o_addr, 32'h200);
      end
    end
    if (!found) chk("mis_resume_timeout", 32'd0, 32'd1);

    // Randomized traffic with redirects.
    knobs(75, 65, 70, 5);
    repeat (400) step();

    // Asynchronous reset in the middle of a stalled stream.
    knobs(100, 100, 100, 0);
    force_flush = 1'b1; flush_tgt = 32'h40;
    step();
    force_flush = 1'b0;
    repeat (4) step();
    knobs(100, 0, 100, 0);
    repeat (8) step();
    do_reset(1);
    knobs(75, 65, 70, 5);
    repeat (60) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
